// File: rtl/utopia_rx_arbiter_if.sv
// Bundle of receiver-side and downstream-side signals around the UTOPIA RX arbiter.
// master: the arbiter itself; slave: the receivers plus downstream stage.
interface utopia_rx_arbiter_if #(
   parameter int unsigned NUM_RX = 4,
   parameter int unsigned CELL_W = 424,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned PortW = $clog2(NUM_RX);

   logic [NUM_RX-1:0]        port_en;
   logic [NUM_RX-1:0]        rx_valid;
   logic [NUM_RX*CELL_W-1:0] rx_cell;
   logic [NUM_RX-1:0]        rx_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic [CELL_W-1:0]        out_cell;
   logic [PortW-1:0]         out_port;
   logic [CNT_W-1:0]         cells_fwd;

   modport master (
      input  port_en, rx_valid, rx_cell, out_ready,
      output rx_ready, out_valid, out_cell, out_port, cells_fwd
   );

   modport slave (
      output port_en, rx_valid, rx_cell, out_ready,
      input  rx_ready, out_valid, out_cell, out_port, cells_fwd
   );
endinterface

// File: rtl/utopia_rx_arbiter.sv
// Round-robin scheduler granting one completed UTOPIA cell per cycle from NUM_RX
// receivers into a single-entry output register, with per-port arm/release FSMs.
module utopia_rx_arbiter #(
   parameter int unsigned NUM_RX = 4,
   parameter int unsigned CELL_W = 424,
   parameter int unsigned CNT_W  = 16
) (
   input logic                 clk_in,
   input logic                 reset,
   utopia_rx_arbiter_if.master bus
);
   localparam int unsigned PortW = $clog2(NUM_RX);

   typedef enum logic [1:0] {StIdle, StArmed, StRelease} port_state_e;

   port_state_e       state_q [NUM_RX];
   port_state_e       state_d [NUM_RX];
   logic [NUM_RX-1:0] rx_ready_q, rx_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [CELL_W-1:0] out_cell_q, out_cell_d;
   logic [PortW-1:0]  out_port_q, out_port_d;
   logic [PortW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cells_fwd_q, cells_fwd_d;

   logic [NUM_RX-1:0]   eligible;
   logic [2*NUM_RX-1:0] eligible_dbl;
   logic [NUM_RX-1:0]   eligible_rot;
   logic                slot_free;
   logic                grant_vld;
   logic [PortW-1:0]    grant_idx;
   int unsigned         scan_idx;

   always_comb begin
      for (int i = 0; i < NUM_RX; i++) begin
         eligible[i] = (state_q[i] == StArmed) && bus.rx_valid[i];
      end
   end

   assign slot_free    = !out_valid_q || bus.out_ready;
   // Rotate so bit 0 is the port at rr_ptr; the first set bit is the winner.
   assign eligible_dbl = {eligible, eligible} >> rr_ptr_q;
   assign eligible_rot = eligible_dbl[NUM_RX-1:0];

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NUM_RX; k++) begin
         if (!grant_vld && eligible_rot[k]) begin
            grant_vld = 1'b1;
            scan_idx  = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_RX) scan_idx = scan_idx - NUM_RX;
            grant_idx = PortW'(scan_idx);
         end
      end
      grant_vld = grant_vld && slot_free;
   end

   always_comb begin
      for (int i = 0; i < NUM_RX; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            StIdle:    if (bus.port_en[i] && !bus.rx_valid[i]) state_d[i] = StArmed;
            StArmed:   if (grant_vld && (grant_idx == PortW'(i))) state_d[i] = StRelease;
            StRelease: if (!bus.rx_valid[i]) state_d[i] = StIdle;
            default:   state_d[i] = StIdle;
         endcase
         // Rises one cycle after arming, drops on the very edge the port is granted.
         rx_ready_d[i] = (state_q[i] == StArmed) && (state_d[i] == StArmed);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q && !bus.out_ready;
      out_cell_d  = out_cell_q;
      out_port_d  = out_port_q;
      rr_ptr_d    = rr_ptr_q;
      cells_fwd_d = cells_fwd_q;
      if (grant_vld) begin
         out_valid_d = 1'b1;
         out_port_d  = grant_idx;
         for (int i = 0; i < NUM_RX; i++) begin
            if (grant_idx == PortW'(i)) out_cell_d = bus.rx_cell[i*CELL_W +: CELL_W];
         end
         rr_ptr_d    = (grant_idx == PortW'(NUM_RX - 1)) ? '0 : grant_idx + PortW'(1);
         cells_fwd_d = cells_fwd_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         for (int i = 0; i < NUM_RX; i++) state_q[i] <= StIdle;
         rx_ready_q  <= '0;
         out_valid_q <= 1'b0;
         out_cell_q  <= '0;
         out_port_q  <= '0;
         rr_ptr_q    <= '0;
         cells_fwd_q <= '0;
      end else begin
         for (int i = 0; i < NUM_RX; i++) state_q[i] <= state_d[i];
         rx_ready_q  <= rx_ready_d;
         out_valid_q <= out_valid_d;
         out_cell_q  <= out_cell_d;
         out_port_q  <= out_port_d;
         rr_ptr_q    <= rr_ptr_d;
         cells_fwd_q <= cells_fwd_d;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_cell  = out_cell_q;
   assign bus.out_port  = out_port_q;
   assign bus.cells_fwd = cells_fwd_q;
endmodule
